mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the pipelined MIPS core, sitting between the EX/MEM and MEM/WB pipeline registers. It consumes the EX/MEM latch contents, runs the data-cache request/`dhit` handshake, stalls upstream stages while a load or store is outstanding, and registers the result into the MEM/WB latch fields consumed by writeback. It also owns the sticky halt flag and, optionally, the LL/SC link register.

## Interface
Parameters:
- none (widths fixed by `cpu_types_pkg`: `word_t` = 32, `regbits_t` = 5)

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `CLK` in 1 — core clock, rising edge.
- `RST` in 1 — asynchronous, active-high reset.
- `ex_valid` in 1 — EX/MEM holds a real instruction (0 = bubble).
- `ex_dREN`, `ex_dWEN` in 1 — load / store request.
- `ex_ll`, `ex_sc` in 1 — load-linked / store-conditional. Ignored when the macro is off.
- `ex_ALUOut` in 32 — effective address or ALU result.
- `ex_store` in 32 — store data.
- `ex_npc` in 32 — PC+4, used for JAL writeback.
- `ex_rd` in 5 — destination register.
- `ex_RegWEN` in 1 — register write enable.
- `ex_MemtoReg` in `memtoreg_t` — writeback source select.
- `ex_halt` in 1 — HALT instruction.
- `dhit` in 1 — cache completed the request.
- `dmemload` in 32 — cache read data.
- `dmemREN`, `dmemWEN` out 1 — cache request strobes.
- `dmemaddr` out 32 — cache address.
- `dmemstore` out 32 — cache write data.
- `mm_stall` out 1 — freeze IF/ID/EX and EX/MEM.
- `wb_valid` out 1 — MEM/WB holds a real instruction.
- `wb_rd` out 5, `wb_RegWEN` out 1, `wb_MemtoReg` out `memtoreg_t` — registered copies of the EX/MEM fields.
- `wb_ALUOut`, `wb_load`, `wb_npc` out 32 — registered copies; `wb_load` holds the load data or the SC result.
- `wb_halt` out 1 — sticky halt flag.

## Operation
- Memory op: `mop = ex_valid & (ex_dREN | ex_dWEN) & ~wb_halt`.
- Request outputs:
  - `dmemaddr = ex_ALUOut`
  - `dmemstore = ex_store`
  - `dmemREN = mop & ex_dREN`
  - `dmemWEN = mop & ex_dWEN` (gated further by the SC rule below)
- FSM has two states:
  - IDLE: `mop` with `dhit` stays in IDLE. `mop` without `dhit` goes to WAIT.
  - WAIT: strobes stay asserted and inputs are held stable by `mm_stall`. `dhit` returns to IDLE.
- Stall: `mm_stall = mop & ~dhit`, in either state.
- MEM/WB latch:
  - On every rising edge with `mm_stall` = 0, load the `ex_*` fields and set `wb_valid = ex_valid & ~wb_halt`.
  - `wb_load` takes `dmemload` on a load.
  - With `mm_stall` = 1, `wb_valid` is 0 (bubble) and the `wb_*` data fields hold.
- Halt: a valid `ex_halt` passes through with `mm_stall` = 0 and sets `wb_halt` on that edge. `wb_halt` stays set until `RST`. While it is set, no requests issue and `wb_valid` stays 0.
- A store never writes the register file unless `ex_RegWEN` is set; the block does not reinterpret control bits.

## Timing
- Reset: every output and every register is 0 and the FSM is in IDLE. This covers `dmemREN`, `dmemWEN`, `mm_stall`, all `wb_*`, `wb_halt` and the link state.
- Asserting `RST` mid-WAIT aborts the request immediately (strobes drop asynchronously with the state).
- Latency:
  - Non-memory instruction: 1 cycle from EX/MEM to MEM/WB.
  - Memory op: 1 cycle plus the number of cycles `dhit` stays low.
- Handshake:
  - Strobes are a pure function of `mop` and state. There is no extra cycle after `dhit`.
  - `dhit` in the same cycle as the request completes it with zero stall.
  - `dhit` outside a request is ignored.
- `dmemREN` and `dmemWEN` are never both 1. If both `ex_dREN` and `ex_dWEN` are set, the read wins.

## Configuration
- `MM_ATOMIC_EN` defined:
  - Link state is a 32-bit `linkaddr` plus a `linkvalid` bit.
  - A completed LL sets `linkaddr = ex_ALUOut` and `linkvalid = 1`.
  - SC with `linkvalid` set and a matching address issues the write. On `dhit` it clears `linkvalid` and sets `wb_load = 1`.
  - SC otherwise issues no write, does not stall, and sets `wb_load = 0`.
  - Any completed SW to `linkaddr` clears `linkvalid`.
- `MM_ATOMIC_EN` undefined: `ex_ll` and `ex_sc` are ignored, LL behaves as LW, SC behaves as SW, and no link registers exist.

## Test plan
- Reset with `RST` = 1 mid-run, all inputs toggling → every output 0. After release, the first ADD (rd = 3, ALUOut = 0x10) appears at `wb_valid` = 1, `wb_rd` = 3 one cycle later.
- LW at addr 0x40, `dhit` low for 3 cycles then high with `dmemload` = 0xDEADBEEF → `dmemREN` high for 4 cycles, `mm_stall` high for 3, then `wb_load` = 0xDEADBEEF with `wb_valid` = 1. Bubbles are visible during the stall.
- SW 0x1234 to 0x80 with `dhit` in the same cycle → `dmemWEN` = 1, `dmemstore` = 0x1234, `mm_stall` = 0, no WAIT entry.
- HALT followed by LW → `wb_halt` = 1 on the next edge. The LW produces no `dmemREN`, `wb_valid` stays 0, and `wb_halt` stays 1 until `RST`.
- (`MM_ATOMIC_EN`) LL 0x100, then SC 0x100 → `dmemWEN` = 1 and `wb_load` = 1. A second SC 0x100 → no `dmemWEN`, `wb_load` = 0.
- (`MM_ATOMIC_EN`) LL 0x100, SW 0x100, then SC 0x100 → the SC fails with `wb_load` = 0 and no write.

Source files
------------

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM -> dcache handshake -> MEM/WB latch, sticky halt.
// Optional LL/SC link register enabled by defining MM_ATOMIC_EN.
module mem_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic        ex_dREN,
  input  logic        ex_dWEN,
  input  logic        ex_ll,
  input  logic        ex_sc,
  input  logic [31:0] ex_ALUOut,
  input  logic [31:0] ex_store,
  input  logic [31:0] ex_npc,
  input  logic [4:0]  ex_rd,
  input  logic        ex_RegWEN,
  input  logic [1:0]  ex_MemtoReg,
  input  logic        ex_halt,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mm_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_RegWEN,
  output logic [1:0]  wb_MemtoReg,
  output logic [31:0] wb_ALUOut,
  output logic [31:0] wb_load,
  output logic [31:0] wb_npc,
  output logic        wb_halt
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state, state_n;
  logic   live;
  logic   mop;
  logic   rd_req;
  logic   wr_try;
  logic   wr_req;
  logic   req;

  // Gating with ~RST makes every output drop the instant reset asserts
  assign live   = ~RST;
  assign mop    = live & ex_valid & (ex_dREN | ex_dWEN) & ~wb_halt;
  assign rd_req = mop & ex_dREN;
  assign wr_try = mop & ex_dWEN & ~ex_dREN;

`ifdef MM_ATOMIC_EN
  logic [31:0] linkaddr;
  logic        linkvalid;
  logic        sc_op;
  logic        sc_ok;

  assign sc_op  = wr_try & ex_sc;
  assign sc_ok  = linkvalid & (linkaddr == ex_ALUOut);
  assign wr_req = wr_try & ~(ex_sc & ~sc_ok);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      linkaddr  <= '0;
      linkvalid <= 1'b0;
    end else if (rd_req & dhit & ex_ll) begin
      linkaddr  <= ex_ALUOut;
      linkvalid <= 1'b1;
    end else if (wr_req & dhit & (ex_ALUOut == linkaddr)) begin
      linkvalid <= 1'b0;
    end
  end
`else
  logic unused_atomic;

  assign unused_atomic = ex_ll ^ ex_sc;
  assign wr_req        = wr_try;
`endif

  assign req = rd_req | wr_req;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (req & ~dhit) state_n = S_WAIT;
      S_WAIT: if (dhit | ~req) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    dmemREN   = rd_req;
    dmemWEN   = wr_req;
    mm_stall  = req & ~dhit;
    dmemaddr  = live ? ex_ALUOut : '0;
    dmemstore = live ? ex_store : '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_RegWEN   <= 1'b0;
      wb_MemtoReg <= '0;
      wb_ALUOut   <= '0;
      wb_load     <= '0;
      wb_npc      <= '0;
      wb_halt     <= 1'b0;
    end else if (mm_stall) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid    <= ex_valid & ~wb_halt;
      wb_rd       <= ex_rd;
      wb_RegWEN   <= ex_RegWEN;
      wb_MemtoReg <= ex_MemtoReg;
      wb_ALUOut   <= ex_ALUOut;
      wb_npc      <= ex_npc;
      if (rd_req) wb_load <= dmemload;
`ifdef MM_ATOMIC_EN
      if (sc_op) wb_load <= {31'b0, sc_ok};
`endif
      if (ex_valid & ex_halt) wb_halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized + directed bench for mem_stage against a behavioural model.
// Define MM_ATOMIC_EN to also cover LL/SC.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ex_valid, ex_dREN, ex_dWEN, ex_ll, ex_sc;
  logic [31:0] ex_ALUOut, ex_store, ex_npc;
  logic [4:0]  ex_rd;
  logic        ex_RegWEN;
  logic [1:0]  ex_MemtoReg;
  logic        ex_halt, dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN, mm_stall;
  logic [31:0] dmemaddr, dmemstore;
  logic        wb_valid, wb_RegWEN, wb_halt;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_MemtoReg;
  logic [31:0] wb_ALUOut, wb_load, wb_npc;

  mem_stage dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
    .ex_ll(ex_ll), .ex_sc(ex_sc),
    .ex_ALUOut(ex_ALUOut), .ex_store(ex_store), .ex_npc(ex_npc),
    .ex_rd(ex_rd), .ex_RegWEN(ex_RegWEN), .ex_MemtoReg(ex_MemtoReg),
    .ex_halt(ex_halt), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mm_stall(mm_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_RegWEN(wb_RegWEN),
    .wb_MemtoReg(wb_MemtoReg), .wb_ALUOut(wb_ALUOut),
    .wb_load(wb_load), .wb_npc(wb_npc), .wb_halt(wb_halt)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // Model of the MEM/WB latch and link state
  logic        m_valid, m_RegWEN, m_halt, m_lv;
  logic [4:0]  m_rd;
  logic [1:0]  m_MemtoReg;
  logic [31:0] m_ALUOut, m_load, m_npc, m_la;
  logic        hold;

  // Combinational outputs sampled during the last tick
  logic        s_ren, s_wen, s_stall;
  logic [31:0] s_store;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_RegWEN = 0; m_halt = 0; m_lv = 0;
    m_rd = 0; m_MemtoReg = 0; m_ALUOut = 0; m_load = 0;
    m_npc = 0; m_la = 0; hold = 0;
  endtask

  task automatic set_op(logic v, logic ren, logic wen, logic [31:0] addr,
                        logic [31:0] sd, logic [4:0] rd, logic regwen);
    ex_valid = v; ex_dREN = ren; ex_dWEN = wen;
    ex_ALUOut = addr; ex_store = sd; ex_rd = rd; ex_RegWEN = regwen;
    ex_npc = addr + 32'd4; ex_MemtoReg = {1'b0, ren};
    ex_ll = 0; ex_sc = 0; ex_halt = 0;
  endtask

  task automatic rnd_inputs();
    if (!hold) begin
      ex_valid = $urandom_range(0, 3) != 0;
      {ex_dREN, ex_dWEN} = 2'($urandom_range(0, 3));
      ex_ll = $urandom_range(0, 1) != 0;
      ex_sc = $urandom_range(0, 1) != 0;
      ex_ALUOut = 32'h100 + 32'($urandom_range(0, 2)) * 4;
      ex_store = $urandom;
      ex_npc = $urandom;
      ex_rd = 5'($urandom_range(0, 31));
      ex_RegWEN = $urandom_range(0, 1) != 0;
      ex_MemtoReg = 2'($urandom_range(0, 3));
      ex_halt = 0;
    end
    dhit = $urandom_range(0, 1) != 0;
    dmemload = $urandom;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, " dmemREN"}, dmemREN, 0);
    chk({tag, " dmemWEN"}, dmemWEN, 0);
    chk({tag, " dmemaddr"}, dmemaddr, 0);
    chk({tag, " dmemstore"}, dmemstore, 0);
    chk({tag, " mm_stall"}, mm_stall, 0);
    chk({tag, " wb_valid"}, wb_valid, 0);
    chk({tag, " wb_rd"}, wb_rd, 0);
    chk({tag, " wb_RegWEN"}, wb_RegWEN, 0);
    chk({tag, " wb_MemtoReg"}, wb_MemtoReg, 0);
    chk({tag, " wb_ALUOut"}, wb_ALUOut, 0);
    chk({tag, " wb_load"}, wb_load, 0);
    chk({tag, " wb_npc"}, wb_npc, 0);
    chk({tag, " wb_halt"}, wb_halt, 0);
  endtask

  // Called at posedge+1 with inputs set; returns at next posedge+1
  task automatic tick();
    logic rd, wr, st, ok, sc;
    #2;
    rd = ex_valid & ex_dREN & ~m_halt;
    wr = ex_valid & ex_dWEN & ~ex_dREN & ~m_halt;
    sc = 0;
    ok = 0;
`ifdef MM_ATOMIC_EN
    sc = wr & ex_sc;
    ok = m_lv && (m_la == ex_ALUOut);
    if (sc && !ok) wr = 0;
`endif
    st = (rd | wr) & ~dhit;
    chk("dmemREN", dmemREN, rd);
    chk("dmemWEN", dmemWEN, wr);
    chk("mm_stall", mm_stall, st);
    chk("dmemaddr", dmemaddr, ex_ALUOut);
    chk("dmemstore", dmemstore, ex_store);
    s_ren = dmemREN; s_wen = dmemWEN; s_stall = mm_stall; s_store = dmemstore;
    if (st) begin
      m_valid = 0;
    end else begin
      m_valid = ex_valid & ~m_halt;
      m_rd = ex_rd; m_RegWEN = ex_RegWEN; m_MemtoReg = ex_MemtoReg;
      m_ALUOut = ex_ALUOut; m_npc = ex_npc;
      if (rd) m_load = dmemload;
      if (sc) m_load = {31'b0, ok};
      if (rd && ex_ll && dhit) begin m_la = ex_ALUOut; m_lv = 1; end
      else if (wr && dhit && ex_ALUOut == m_la) m_lv = 0;
      if (ex_valid && ex_halt) m_halt = 1;
    end
    hold = st;
    @(posedge CLK);
    #1;
    chk("wb_valid", wb_valid, m_valid);
    chk("wb_rd", wb_rd, m_rd);
    chk("wb_RegWEN", wb_RegWEN, m_RegWEN);
    chk("wb_MemtoReg", wb_MemtoReg, m_MemtoReg);
    chk("wb_ALUOut", wb_ALUOut, m_ALUOut);
    chk("wb_load", wb_load, m_load);
    chk("wb_npc", wb_npc, m_npc);
    chk("wb_halt", wb_halt, m_halt);
  endtask

  initial begin
    m_reset();
    set_op(0, 0, 0, 0, 0, 0, 0);
    dhit = 0; dmemload = 0;
    RST = 1;
    #1;
    chk_all_zero("por");
    @(posedge CLK); #1;
    RST = 0;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rnd_inputs();
      tick();
    end

    // Reset mid-WAIT with inputs toggling
    set_op(1, 1, 0, 32'h40, 0, 5'd7, 1);
    dhit = 0;
    tick();
    chk("pre-reset stall", s_stall, 1);
    RST = 1;
    #2;
    chk_all_zero("rst");
    m_reset();
    @(posedge CLK); #1;
    hold = 0;
    rnd_inputs();
    #2;
    chk_all_zero("rst2");
    @(posedge CLK); #1;
    RST = 0;
    set_op(1, 0, 0, 32'h10, 0, 5'd3, 1);
    dhit = 0;
    tick();
    chk("add wb_valid", wb_valid, 1);
    chk("add wb_rd", wb_rd, 3);
    chk("add wb_ALUOut", wb_ALUOut, 32'h10);

    // LW with three miss cycles
    set_op(1, 1, 0, 32'h40, 0, 5'd8, 1);
    dhit = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw wait ren", s_ren, 1);
      chk("lw wait stall", s_stall, 1);
      chk("lw bubble", wb_valid, 0);
    end
    dhit = 1; dmemload = 32'hDEADBEEF;
    tick();
    chk("lw hit ren", s_ren, 1);
    chk("lw hit stall", s_stall, 0);
    chk("lw wb_load", wb_load, 32'hDEADBEEF);
    chk("lw wb_valid", wb_valid, 1);

    // SW with same-cycle hit
    set_op(1, 0, 1, 32'h80, 32'h1234, 5'd0, 0);
    dhit = 1;
    tick();
    chk("sw wen", s_wen, 1);
    chk("sw store", s_store, 32'h1234);
    chk("sw stall", s_stall, 0);
    chk("sw ren", s_ren, 0);

    // Both read and write requested: read wins
    set_op(1, 1, 1, 32'h84, 32'h55, 5'd9, 1);
    dhit = 1; dmemload = 32'h0BADF00D;
    tick();
    chk("rw ren", s_ren, 1);
    chk("rw wen", s_wen, 0);
    chk("rw wb_load", wb_load, 32'h0BADF00D);

`ifdef MM_ATOMIC_EN
    set_op(1, 1, 0, 32'h100, 0, 5'd4, 1);
    ex_ll = 1; dhit = 1;
    tick();
    set_op(1, 0, 1, 32'h100, 32'h77, 5'd4, 1);
    ex_sc = 1; dhit = 1;
    tick();
    chk("sc1 wen", s_wen, 1);
    chk("sc1 wb_load", wb_load, 1);
    dhit = 0;
    tick();
    chk("sc2 wen", s_wen, 0);
    chk("sc2 stall", s_stall, 0);
    chk("sc2 wb_load", wb_load, 0);
    set_op(1, 1, 0, 32'h100, 0, 5'd4, 1);
    ex_ll = 1; dhit = 1;
    tick();
    set_op(1, 0, 1, 32'h100, 32'h99, 5'd0, 0);
    dhit = 1;
    tick();
    set_op(1, 0, 1, 32'h100, 32'h77, 5'd4, 1);
    ex_sc = 1; dhit = 1;
    tick();
    chk("sc3 wen", s_wen, 0);
    chk("sc3 wb_load", wb_load, 0);
`endif

    // HALT then LW
    set_op(1, 0, 0, 32'h0, 0, 5'd0, 0);
    ex_halt = 1; dhit = 0;
    tick();
    chk("halt set", wb_halt, 1);
    chk("halt wb_valid", wb_valid, 1);
    set_op(1, 1, 0, 32'h40, 0, 5'd5, 1);
    dhit = 0;
    tick();
    chk("halted lw ren", s_ren, 0);
    chk("halted lw stall", s_stall, 0);
    chk("halted wb_valid", wb_valid, 0);
    chk("halt sticky", wb_halt, 1);
    hold = 0;
    for (int i = 0; i < 20; i++) begin
      rnd_inputs();
      tick();
    end
    chk("halt still", wb_halt, 1);
    RST = 1;
    #2;
    chk("halt cleared", wb_halt, 0);
    @(posedge CLK); #1;
    RST = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
